// File: rtl/tmds_encoder.sv
// TMDS symbol encoder for one HDMI/DVI channel.
// Two-stage pipeline: stage 1 builds the transition-minimised q_m word,
// stage 2 applies DC balancing (video) or looks up the fixed code for
// control, TERC4 and guard-band periods. Latency is 2 cycles in every mode.
module tmds_encoder #(
   parameter int CHANNEL = 0
) (
   input  logic       ref_clk_i,
   input  logic       rst_n,
   input  logic [1:0] mode_i,
   input  logic [7:0] dat_i,
   input  logic [1:0] ctrl_i,
   input  logic [3:0] terc4_i,
   output logic [9:0] tmds_o,
   output logic [4:0] disp_o
);

   localparam logic [1:0] MODE_CTRL  = 2'd0;
   localparam logic [1:0] MODE_VIDEO = 2'd1;
   localparam logic [1:0] MODE_TERC4 = 2'd2;
   localparam logic [1:0] MODE_GUARD = 2'd3;

   localparam logic [9:0] GUARD_CODE = (CHANNEL == 1) ? 10'h133 : 10'h2CC;

   logic [3:0]        n1_d;
   logic              use_xnor;
   logic              chain;
   logic [8:0]        qm_d;

   logic [1:0]        mode_s1;
   logic [1:0]        ctrl_s1;
   logic [3:0]        terc4_s1;
   logic [8:0]        qm_s1;

   logic [3:0]        n1_q;
   logic signed [4:0] bal;
   logic signed [4:0] cnt;
   logic signed [4:0] cnt_nxt;
   logic [9:0]        sym_nxt;

   // Stage 1 combinational: choose XOR/XNOR chaining to minimise transitions
   always_comb begin
      n1_d = '0;
      for (int i = 0; i < 8; i++) begin
         n1_d = n1_d + {3'b000, dat_i[i]};
      end
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !dat_i[0]);
      qm_d     = '0;
      chain    = dat_i[0];
      qm_d[0]  = dat_i[0];
      for (int i = 1; i < 8; i++) begin
         chain   = use_xnor ? ~(chain ^ dat_i[i]) : (chain ^ dat_i[i]);
         qm_d[i] = chain;
      end
      qm_d[8] = ~use_xnor;
   end

   // Stage 1 registers: capture symbol type, side-band inputs and q_m
   always_ff @(posedge ref_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         mode_s1  <= MODE_CTRL;
         ctrl_s1  <= '0;
         terc4_s1 <= '0;
         qm_s1    <= '0;
      end else begin
         mode_s1  <= mode_i;
         ctrl_s1  <= ctrl_i;
         terc4_s1 <= terc4_i;
         qm_s1    <= qm_d;
      end
   end

   // Stage 2 combinational: balance of q_m[7:0] expressed as N1-N0
   always_comb begin
      n1_q = '0;
      for (int i = 0; i < 8; i++) begin
         n1_q = n1_q + {3'b000, qm_s1[i]};
      end
      bal = $signed({1'b0, n1_q}) - $signed({1'b0, 4'd8 - n1_q});
   end

   // Stage 2 combinational: next symbol and running disparity
   always_comb begin
      sym_nxt = 10'h354;
      cnt_nxt = '0;
      case (mode_s1)
         MODE_CTRL: begin
            case (ctrl_s1)
               2'b00:   sym_nxt = 10'h354;
               2'b01:   sym_nxt = 10'h0AB;
               2'b10:   sym_nxt = 10'h154;
               default: sym_nxt = 10'h2AB;
            endcase
         end
         MODE_VIDEO: begin
            if ((cnt == 5'sd0) || (bal == 5'sd0)) begin
               sym_nxt = {~qm_s1[8], qm_s1[8], qm_s1[8] ? qm_s1[7:0] : ~qm_s1[7:0]};
               cnt_nxt = qm_s1[8] ? (cnt + bal) : (cnt - bal);
            end else if (((cnt > 5'sd0) && (bal > 5'sd0)) ||
                         ((cnt < 5'sd0) && (bal < 5'sd0))) begin
               sym_nxt = {1'b1, qm_s1[8], ~qm_s1[7:0]};
               cnt_nxt = cnt - bal + (qm_s1[8] ? 5'sd2 : 5'sd0);
            end else begin
               sym_nxt = {1'b0, qm_s1[8], qm_s1[7:0]};
               cnt_nxt = cnt + bal - (qm_s1[8] ? 5'sd0 : 5'sd2);
            end
         end
         MODE_TERC4: begin
            case (terc4_s1)
               4'h0:    sym_nxt = 10'h29C;
               4'h1:    sym_nxt = 10'h263;
               4'h2:    sym_nxt = 10'h2E4;
               4'h3:    sym_nxt = 10'h2E2;
               4'h4:    sym_nxt = 10'h171;
               4'h5:    sym_nxt = 10'h11E;
               4'h6:    sym_nxt = 10'h18E;
               4'h7:    sym_nxt = 10'h13C;
               4'h8:    sym_nxt = 10'h2CC;
               4'h9:    sym_nxt = 10'h139;
               4'hA:    sym_nxt = 10'h19C;
               4'hB:    sym_nxt = 10'h2C6;
               4'hC:    sym_nxt = 10'h28E;
               4'hD:    sym_nxt = 10'h271;
               4'hE:    sym_nxt = 10'h163;
               default: sym_nxt = 10'h2C3;
            endcase
         end
         MODE_GUARD: begin
            sym_nxt = GUARD_CODE;
         end
         default: begin
            sym_nxt = 10'h354;
         end
      endcase
   end

   // Stage 2 registers: output symbol and disparity; non-video clears cnt
   always_ff @(posedge ref_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         tmds_o <= 10'h354;
         cnt    <= '0;
      end else begin
         tmds_o <= sym_nxt;
         cnt    <= cnt_nxt;
      end
   end

   assign disp_o = cnt;

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed sequences plus randomized
// mixed-mode traffic compared against a behavioural symbol model.
module tb_tmds_encoder;

   logic       ref_clk_i = 1'b0;
   logic       rst_n;
   logic [1:0] mode_i;
   logic [7:0] dat_i;
   logic [1:0] ctrl_i;
   logic [3:0] terc4_i;
   logic [9:0] tmds0, tmds1;
   logic [4:0] disp0, disp1;

   int n_checks = 0;
   int n_fails  = 0;

   tmds_encoder #(.CHANNEL(0)) dut0 (
      .ref_clk_i (ref_clk_i), .rst_n (rst_n), .mode_i (mode_i), .dat_i (dat_i),
      .ctrl_i (ctrl_i), .terc4_i (terc4_i), .tmds_o (tmds0), .disp_o (disp0)
   );

   tmds_encoder #(.CHANNEL(1)) dut1 (
      .ref_clk_i (ref_clk_i), .rst_n (rst_n), .mode_i (mode_i), .dat_i (dat_i),
      .ctrl_i (ctrl_i), .terc4_i (terc4_i), .tmds_o (tmds1), .disp_o (disp1)
   );

   always #5 ref_clk_i = ~ref_clk_i;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [9:0] sym0;
      logic [9:0] sym1;
      int         disp;
      logic       vid;
      logic [7:0] dat;
   } exp_t;

   logic [9:0] ctrl_tab  [4]  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
   logic [9:0] terc4_tab [16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2,
                                  10'h171, 10'h11E, 10'h18E, 10'h13C,
                                  10'h2CC, 10'h139, 10'h19C, 10'h2C6,
                                  10'h28E, 10'h271, 10'h163, 10'h2C3};

   int   m_cnt;
   exp_t exp_s1, exp_out;

   task automatic check_val(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  tag, act, act, exp, exp, $time);
      end
   endtask

   // Behavioural encoder: one call per symbol, in transmission order.
   function automatic exp_t model(input logic [1:0] m, input logic [7:0] d,
                                  input logic [1:0] c, input logic [3:0] t);
      exp_t       e;
      int         n1, ones, zeros, q8;
      bit         inv_chain;
      logic [8:0] qm;
      e.vid = (m == 2'd1);
      e.dat = d;
      case (m)
         2'd0: begin e.sym0 = ctrl_tab[c];  m_cnt = 0; end
         2'd2: begin e.sym0 = terc4_tab[t]; m_cnt = 0; end
         2'd3: begin e.sym0 = 10'h2CC;      m_cnt = 0; end
         default: begin
            n1        = $countones(d);
            inv_chain = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            qm[0]     = d[0];
            for (int i = 1; i < 8; i++)
               qm[i] = inv_chain ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
            qm[8] = ~inv_chain;
            q8    = qm[8] ? 1 : 0;
            ones  = $countones(qm[7:0]);
            zeros = 8 - ones;
            if (m_cnt == 0 || ones == zeros) begin
               e.sym0 = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
               m_cnt  = m_cnt + (q8 == 1 ? ones - zeros : zeros - ones);
            end else if ((m_cnt > 0 && ones > zeros) || (m_cnt < 0 && zeros > ones)) begin
               e.sym0 = {1'b1, qm[8], ~qm[7:0]};
               m_cnt  = m_cnt + 2 * q8 + zeros - ones;
            end else begin
               e.sym0 = {1'b0, qm[8], qm[7:0]};
               m_cnt  = m_cnt - 2 * (1 - q8) + ones - zeros;
            end
         end
      endcase
      e.sym1 = (m == 2'd3) ? 10'h133 : e.sym0;
      e.disp = m_cnt;
      return e;
   endfunction

   function automatic logic [7:0] decode(input logic [9:0] s);
      logic [7:0] q, d;
      q    = s[9] ? ~s[7:0] : s[7:0];
      d[0] = q[0];
      for (int i = 1; i < 8; i++)
         d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      return d;
   endfunction

   function automatic void reset_model();
      m_cnt   = 0;
      exp_s1  = '{sym0: 10'h354, sym1: 10'h354, disp: 0, vid: 1'b0, dat: 8'h00};
      exp_out = exp_s1;
   endfunction

   task automatic check_outputs();
      int d;
      d = int'($signed(disp0));
      check_val("tmds_ch0", int'(tmds0), int'(exp_out.sym0));
      check_val("tmds_ch1", int'(tmds1), int'(exp_out.sym1));
      check_val("disp_ch0", d, exp_out.disp);
      check_val("disp_ch1", int'($signed(disp1)), exp_out.disp);
      if (exp_out.vid) begin
         check_val("decode", int'(decode(tmds0)), int'(exp_out.dat));
         check_val("disp_legal", int'((d % 2 == 0) && d >= -8 && d <= 8), 1);
      end
   endtask

   // Drive one symbol at the falling edge; inactive inputs get random junk.
   task automatic cycle(input logic [1:0] m, input logic [7:0] v);
      mode_i  = m;
      dat_i   = 8'($urandom);
      ctrl_i  = 2'($urandom);
      terc4_i = 4'($urandom);
      case (m)
         2'd0: ctrl_i  = v[1:0];
         2'd1: dat_i   = v;
         2'd2: terc4_i = v[3:0];
         default: ;
      endcase
      @(posedge ref_clk_i);
      exp_out = exp_s1;
      exp_s1  = model(mode_i, dat_i, ctrl_i, terc4_i);
      @(negedge ref_clk_i);
      check_outputs();
   endtask

   initial begin
      int r;
      rst_n   = 1'b0;
      mode_i  = 2'd0;
      dat_i   = 8'h00;
      ctrl_i  = 2'b00;
      terc4_i = 4'h0;
      reset_model();
      #13;
      check_val("rst_tmds", int'(tmds0), 'h354);
      check_val("rst_disp", int'($signed(disp0)), 0);
      @(negedge ref_clk_i);
      rst_n = 1'b1;

      // Control codes, then video 00 stream interrupted by a control symbol
      cycle(2'd0, 8'h00);
      cycle(2'd0, 8'h01); check_val("ctrl00", int'(tmds0), 'h354);
      cycle(2'd0, 8'h02); check_val("ctrl01", int'(tmds0), 'h0AB);
      cycle(2'd0, 8'h03); check_val("ctrl10", int'(tmds0), 'h154);
      cycle(2'd1, 8'h00); check_val("ctrl11", int'(tmds0), 'h2AB);
      cycle(2'd1, 8'h00);
      check_val("vid00_a", int'(tmds0), 'h100);
      check_val("vid00_a_disp", int'($signed(disp0)), -8);
      cycle(2'd1, 8'h00);
      check_val("vid00_b", int'(tmds0), 'h3FF);
      check_val("vid00_b_disp", int'($signed(disp0)), 2);
      cycle(2'd0, 8'h00);
      check_val("vid00_c", int'(tmds0), 'h100);
      check_val("vid00_c_disp", int'($signed(disp0)), -6);
      cycle(2'd1, 8'h00);
      check_val("ctrl_mid_disp", int'($signed(disp0)), 0);
      cycle(2'd2, 8'h00);
      check_val("vid_after_ctrl", int'(tmds0), 'h100);
      check_val("vid_after_ctrl_disp", int'($signed(disp0)), -8);

      // TERC4 sweep followed by guard band
      for (int i = 1; i < 16; i++) begin
         cycle(2'd2, 8'(i));
         check_val("terc4", int'(tmds0), int'(terc4_tab[i-1]));
      end
      cycle(2'd3, 8'h00); check_val("terc4_f", int'(tmds0), 'h2C3);
      cycle(2'd0, 8'h00);
      check_val("guard_ch0", int'(tmds0), 'h2CC);
      check_val("guard_ch1", int'(tmds1), 'h133);

      // Pure random video run
      for (int i = 0; i < 4000; i++) cycle(2'd1, 8'($urandom));

      // Mixed traffic, mostly video with frequent mode switches
      for (int i = 0; i < 6000; i++) begin
         r = $urandom_range(9, 0);
         if (r < 7)       cycle(2'd1, 8'($urandom));
         else if (r == 7) cycle(2'd0, 8'($urandom));
         else if (r == 8) cycle(2'd2, 8'($urandom));
         else             cycle(2'd3, 8'($urandom));
      end

      // Asynchronous reset mid video stream
      cycle(2'd0, 8'h00);
      cycle(2'd1, 8'h00);
      cycle(2'd1, 8'h00);
      check_val("pre_rst_disp", int'($signed(disp0)), -8);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_rst_tmds", int'(tmds0), 'h354);
      check_val("async_rst_disp", int'($signed(disp0)), 0);
      reset_model();
      @(negedge ref_clk_i);
      check_outputs();
      rst_n = 1'b1;
      cycle(2'd1, 8'h00);
      cycle(2'd0, 8'h00);
      check_val("post_rst_vid", int'(tmds0), 'h100);
      check_val("post_rst_disp", int'($signed(disp0)), -8);
      cycle(2'd0, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
